// File: rtl/pe_result_packer.sv
// Writeback packer: truncates PE results to EEW and packs them into 32-bit register words with byte enables.
// Optional macro PE_RESULT_PACKER_SKID_EN adds a second word buffer so collection overlaps the write.
module pe_result_packer #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        vsew,
    input  logic [1:0]        widening,
    input  logic [ADDR_W-1:0] vd_addr,
    input  logic [CNT_W-1:0]  vl,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_mask,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CNT_W-1:0]  wr_word,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    state_t             state;
    logic [1:0]         eew;
    logic [1:0]         slot;
    logic [CNT_W-1:0]   remaining;

    logic [2:0]         eew_sum_c;
    logic [1:0]         eew_start_c;
    logic [1:0]         last_slot_c;
    logic [31:0]        place_data_c;
    logic [3:0]         place_be_c;
    logic               accept_c;
    logic               word_done_c;

    // EEW code saturates at 32b
    assign eew_sum_c   = 3'(vsew) + 3'(widening);
    assign eew_start_c = (eew_sum_c > 3'd2) ? 2'd2 : eew_sum_c[1:0];

    assign accept_c    = in_valid && in_ready;
    assign word_done_c = (slot == last_slot_c) || (remaining == CNT_W'(1));

    // Position the truncated element and its byte enables in the current slot
    always_comb begin
        place_data_c = '0;
        place_be_c   = '0;
        last_slot_c  = 2'd0;
        case (eew)
            2'd0: begin
                last_slot_c  = 2'd3;
                place_data_c = 32'(in_data[7:0]) << {slot, 3'b000};
                place_be_c   = 4'(in_mask) << slot;
            end
            2'd1: begin
                last_slot_c  = 2'd1;
                place_data_c = 32'(in_data[15:0]) << {slot[0], 4'b0000};
                place_be_c   = 4'({in_mask, in_mask}) << {slot[0], 1'b0};
            end
            default: begin
                last_slot_c  = 2'd0;
                place_data_c = in_data;
                place_be_c   = {4{in_mask}};
            end
        endcase
    end

`ifdef PE_RESULT_PACKER_SKID_EN

    logic [31:0]        col_data;
    logic [3:0]         col_be;
    logic               col_full;
    logic [CNT_W-1:0]   word_cnt;

    logic               out_free_c;
    logic               load_out_c;
    logic               col_full_next_c;
    logic               wr_valid_next_c;
    logic [CNT_W-1:0]   rem_next_c;

    // Output buffer can take a word when empty or being drained this cycle
    assign out_free_c      = !wr_valid || wr_ready;
    assign load_out_c      = col_full ? out_free_c : (accept_c && word_done_c && out_free_c);
    assign col_full_next_c = col_full ? !out_free_c : (accept_c && word_done_c && !out_free_c);
    assign wr_valid_next_c = (wr_valid && !wr_ready) || load_out_c;
    assign rem_next_c      = accept_c ? remaining - CNT_W'(1) : remaining;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            eew       <= 2'd0;
            slot      <= 2'd0;
            remaining <= '0;
            col_data  <= '0;
            col_be    <= '0;
            col_full  <= 1'b0;
            word_cnt  <= '0;
            in_ready  <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_word   <= '0;
            wr_data   <= '0;
            wr_be     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        eew       <= eew_start_c;
                        wr_addr   <= vd_addr;
                        remaining <= vl;
                        slot      <= 2'd0;
                        word_cnt  <= '0;
                        wr_word   <= '0;
                        col_data  <= '0;
                        col_be    <= '0;
                        col_full  <= 1'b0;
                        busy      <= 1'b1;
                        if (vl != '0) begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= FINISH;
                        end
                    end
                end
                COLLECT: begin
                    if (wr_valid && wr_ready) begin
                        wr_valid <= 1'b0;
                        wr_data  <= '0;
                        wr_be    <= '0;
                    end
                    if (col_full) begin
                        if (out_free_c) begin
                            wr_valid <= 1'b1;
                            wr_data  <= col_data;
                            wr_be    <= col_be;
                            wr_word  <= word_cnt;
                            word_cnt <= word_cnt + CNT_W'(1);
                            col_data <= '0;
                            col_be   <= '0;
                            col_full <= 1'b0;
                        end
                    end else if (accept_c) begin
                        remaining <= remaining - CNT_W'(1);
                        if (word_done_c) begin
                            slot <= 2'd0;
                            if (out_free_c) begin
                                wr_valid <= 1'b1;
                                wr_data  <= col_data | place_data_c;
                                wr_be    <= col_be | place_be_c;
                                wr_word  <= word_cnt;
                                word_cnt <= word_cnt + CNT_W'(1);
                                col_data <= '0;
                                col_be   <= '0;
                            end else begin
                                col_data <= col_data | place_data_c;
                                col_be   <= col_be | place_be_c;
                                col_full <= 1'b1;
                            end
                        end else begin
                            slot     <= slot + 2'd1;
                            col_data <= col_data | place_data_c;
                            col_be   <= col_be | place_be_c;
                        end
                    end
                    in_ready <= (rem_next_c != '0) && !col_full_next_c;
                    if ((rem_next_c == '0) && !col_full_next_c) begin
                        state <= wr_valid_next_c ? WRITE : FINISH;
                    end
                end
                WRITE: begin
                    in_ready <= 1'b0;
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        wr_data  <= '0;
                        wr_be    <= '0;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`else

    // Single buffer: the output word registers double as the collect buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            eew       <= 2'd0;
            slot      <= 2'd0;
            remaining <= '0;
            in_ready  <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_word   <= '0;
            wr_data   <= '0;
            wr_be     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        eew       <= eew_start_c;
                        wr_addr   <= vd_addr;
                        remaining <= vl;
                        slot      <= 2'd0;
                        wr_word   <= '0;
                        wr_data   <= '0;
                        wr_be     <= '0;
                        busy      <= 1'b1;
                        if (vl != '0) begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= FINISH;
                        end
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        wr_data   <= wr_data | place_data_c;
                        wr_be     <= wr_be | place_be_c;
                        remaining <= remaining - CNT_W'(1);
                        slot      <= slot + 2'd1;
                        if (word_done_c) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            wr_valid <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        wr_data  <= '0;
                        wr_be    <= '0;
                        slot     <= 2'd0;
                        wr_word  <= wr_word + CNT_W'(1);
                        if (remaining != '0) begin
                            state    <= COLLECT;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: doc/pe_result_packer.md
Name: pe_result_packer

Overview:
- Sequential writeback stage downstream of the 32-bit processing elements.
- Accepts one PE result element per handshake and truncates it to the effective element width (EEW = SEW widened by 0/1/2 steps).
- Packs 8b/16b/32b elements into 32-bit vector-register words with per-byte enables from the element mask, then issues one word write per filled (or final partial) word.
- Performs the inverse of the operand sign-extension/unpacking done ahead of the PE.

Parameters:
- ADDR_W, 5, width of the destination vector-register index.
- CNT_W, 8, width of the element count (vl) and word-index counters.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin operation; latches vsew, widening, vd_addr, vl (honoured only in IDLE)
- vsew  input  2  base element width: 0=8b, 1=16b, 2=32b
- widening  input  2  0=none, 1=widen, 2=quad widen
- vd_addr  input  ADDR_W  destination register index
- vl  input  CNT_W  number of elements to pack
- in_valid  input  1  PE result element valid
- in_ready  output  1  packer can accept an element
- in_data  input  32  PE result (low EEW bits used)
- in_mask  input  1  element active; 0 means byte enables are cleared for that slot
- wr_valid  output  1  word write request
- wr_ready  input  1  register-file write accepted
- wr_addr  output  ADDR_W  latched vd_addr
- wr_word  output  CNT_W  word index within the register group, starting at 0
- wr_data  output  32  packed word
- wr_be  output  4  byte enables
- busy  output  1  high from the start-accepted cycle until return to IDLE
- done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_data=0, wr_be=0, wr_word=0, wr_addr=0, busy=0, done=0. All counters cleared; FSM goes to IDLE.
- EEW code = vsew+widening, saturated at 2 (32b). Elements per word: 4 for 8b, 2 for 16b, 1 for 32b.
- Slot k of a word occupies bytes [k*EEWbytes +: EEWbytes].
- FSM states: IDLE, COLLECT, WRITE, FINISH.
- IDLE:
  - start with vl>0 -> COLLECT; slot=0, remaining=vl, word=0.
  - start with vl=0 -> FINISH; no writes are issued.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready: in_data[EEW-1:0] is written into the current slot; the slot's byte enables are set to in_mask; slot++ and remaining--.
  - The transition to WRITE happens on the accepting handshake when the slot becomes full or remaining becomes 0.
  - Latency: wr_valid is asserted the cycle after the last element of a word is accepted.
- WRITE:
  - in_ready=0.
  - wr_valid=1; wr_data, wr_be and wr_word are held stable until wr_ready.
  - On handshake: word++, slot=0, data and be buffer cleared.
  - Next state: COLLECT if remaining>0, otherwise FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE with busy=0.
- Unfilled slots of a final partial word carry data 0 and be 0.
- start asserted outside IDLE is ignored; latched configuration is unchanged.
- reset asserted mid-operation aborts immediately: no done pulse, and any partial word is discarded.
- wr_ready asserted while wr_valid=0 has no effect.

Optional Feature:
- Macro: PE_RESULT_PACKER_SKID_EN.
- When defined:
  - A second word buffer decouples collection from write.
  - On a fill, the word moves to the output buffer, COLLECT continues, and in_ready stays 1 unless the output buffer is still occupied and the collect buffer is full.
  - wr_valid is driven from the output buffer; done fires only when both buffers are empty and remaining=0.
  - Sustained throughput is 1 element per cycle with wr_ready held at 1.
- When not defined: single buffer as described above; in_ready=0 throughout WRITE.

Test Plan:
- vsew=0, widening=0, vl=4, mask all 1, data 0x11,0x22,0x33,0x44 with wr_ready=1 -> one write: wr_word=0, wr_data=0x44332211, wr_be=4'hF; done pulses once.
- vsew=0, widening=1 (EEW 16b), vl=3, data 0x1234_ABCD, 0x0000_5678, 0xFFFF_9999 -> word0 = 0x5678ABCD with be 4'hF; word1 = 0x00009999 with be 4'h3.
- vsew=1, widening=2 (saturates to 32b), vl=2, second element masked off -> word0 has be 4'hF; word1 has be 4'h0 with data unchanged.
- vl=0 -> no wr_valid; done asserts 2 cycles after start; busy is 1 for those cycles.
- wr_ready held 0 for 5 cycles in WRITE -> wr_data and wr_be stable, in_ready=0 (non-skid build), and a start pulse in this window is ignored.
- reset asserted after 2 of 4 byte elements -> all outputs return to reset values asynchronously, no write or done; a new start afterwards packs correctly from slot 0.
